// File: rtl/axi_dma_rd_buf.sv
// DMA read buffer: DEPTH-word FIFO of AXI_DATA_WIDTH words (plus a last flag),
// followed by an output register that serialises each word into
// AXI_DATA_WIDTH/OUT_WIDTH lanes, least significant lane first.
// A word pushed while the FIFO and the output register are both empty is
// loaded straight into the output register, giving one cycle of latency.
// Optional feature macro: DMA_RD_BUF_OVF_EN (sticky overflow detection).
module axi_dma_rd_buf #(
  parameter int unsigned AXI_DATA_WIDTH = 128,
  parameter int unsigned OUT_WIDTH      = 8,
  parameter int unsigned DEPTH          = 32,
  parameter int unsigned BURST_LEN      = 8
) (
  input  logic                      aclk,
  input  logic                      areset,
  input  logic                      if_wr_push,
  input  logic [AXI_DATA_WIDTH-1:0] if_wr_data,
  input  logic                      st_last,
  output logic                      if_wr_ready,
  output logic                      if_wr_req,
  output logic [OUT_WIDTH-1:0]      m_axis_tdata,
  output logic                      m_axis_tvalid,
  input  logic                      m_axis_tready,
  output logic                      m_axis_tlast,
  output logic [$clog2(DEPTH):0]    level,
  output logic                      ovf
);

  localparam int unsigned RATIO = AXI_DATA_WIDTH / OUT_WIDTH;
  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned PW    = AW + 1;
  localparam int unsigned LW    = (RATIO > 1) ? $clog2(RATIO) : 1;

  logic [AXI_DATA_WIDTH:0]   mem [DEPTH];
  logic [PW-1:0]             wr_ptr_q, rd_ptr_q;
  logic [AXI_DATA_WIDTH-1:0] word_q;
  logic                      last_q;
  logic [LW-1:0]             lane_q;
  logic                      valid_q;

  logic full, empty, lane_last, lane_done, out_free, load_fifo, bypass, wr_en, rd_en;
  logic [31:0] lane_base;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
  assign level = wr_ptr_q - rd_ptr_q;

  assign if_wr_ready = ~full;
  assign if_wr_req   = (PW'(DEPTH) - level) >= PW'(BURST_LEN);

  // Output register frees up when empty or when its final lane leaves this cycle
  assign lane_last = (lane_q == LW'(RATIO - 1));
  assign lane_done = valid_q & m_axis_tready & lane_last;
  assign out_free  = ~valid_q | lane_done;
  assign load_fifo = ~empty & out_free;
  assign bypass    = empty & out_free & if_wr_push;
  assign rd_en     = load_fifo;
  assign wr_en     = if_wr_push & ~full & ~bypass;

  // FIFO storage write; contents need no reset since pointers gate visibility
  always_ff @(posedge aclk) begin
    if (wr_en) mem[wr_ptr_q[AW-1:0]] <= {st_last, if_wr_data};
  end

  // FIFO pointers
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (rd_en) rd_ptr_q <= rd_ptr_q + PW'(1);
    end
  end

  // Output register: reload from FIFO head or bypass, else step through lanes
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      word_q  <= '0;
      last_q  <= 1'b0;
      lane_q  <= '0;
      valid_q <= 1'b0;
    end else if (load_fifo) begin
      {last_q, word_q} <= mem[rd_ptr_q[AW-1:0]];
      lane_q           <= '0;
      valid_q          <= 1'b1;
    end else if (bypass) begin
      word_q  <= if_wr_data;
      last_q  <= st_last;
      lane_q  <= '0;
      valid_q <= 1'b1;
    end else if (lane_done) begin
      lane_q  <= '0;
      valid_q <= 1'b0;
    end else if (valid_q && m_axis_tready) begin
      lane_q <= lane_q + LW'(1);
    end
  end

  // Lane select and stream outputs
  always_comb begin
    lane_base     = 32'(lane_q) * OUT_WIDTH;
    m_axis_tdata  = word_q[lane_base +: OUT_WIDTH];
    m_axis_tvalid = valid_q;
    m_axis_tlast  = valid_q & last_q & lane_last;
  end

`ifdef DMA_RD_BUF_OVF_EN
  logic ovf_q;

  // Sticky overflow: any push attempted while full
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      ovf_q <= 1'b0;
    end else if (if_wr_push && full) begin
      ovf_q <= 1'b1;
    end
  end

  assign ovf = ovf_q;
`else
  assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_axi_dma_rd_buf.sv
// Self-checking bench for axi_dma_rd_buf: directed scenarios plus random traffic,
// lane scoreboard filled at push time and drained by a negedge monitor.
module tb_axi_dma_rd_buf;

  localparam int DW    = 128;
  localparam int OW    = 8;
  localparam int DEPTH = 32;
  localparam int BL    = 8;
  localparam int RATIO = DW / OW;

  logic          aclk = 1'b0;
  logic          areset = 1'b1;
  logic          if_wr_push = 1'b0;
  logic [DW-1:0] if_wr_data = '0;
  logic          st_last = 1'b0;
  logic          if_wr_ready, if_wr_req;
  logic [OW-1:0] m_axis_tdata;
  logic          m_axis_tvalid, m_axis_tlast;
  logic          m_axis_tready = 1'b0;
  logic [5:0]    level;
  logic          ovf;

  axi_dma_rd_buf #(
    .AXI_DATA_WIDTH(DW), .OUT_WIDTH(OW), .DEPTH(DEPTH), .BURST_LEN(BL)
  ) dut (
    .aclk(aclk), .areset(areset), .if_wr_push(if_wr_push), .if_wr_data(if_wr_data),
    .st_last(st_last), .if_wr_ready(if_wr_ready), .if_wr_req(if_wr_req),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast), .level(level), .ovf(ovf)
  );

  always #5 aclk = ~aclk;

  typedef struct packed {
    logic [OW-1:0] d;
    logic          l;
  } lane_t;

  lane_t sb[$];
  int    errors = 0;
  int    checks = 0;
  int    held = 0;      // words in buffer (FIFO + output register)
  int    lane_idx = 0;  // lanes already sent from the oldest word
  bit    ovf_exp = 1'b0;
  int    hs_cnt = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // The output register is always occupied when anything is held, so the
  // FIFO holds everything except that one word.
  function automatic int exp_level();
    return (held > 0) ? held - 1 : 0;
  endfunction

  // Reference model, advanced on each rising edge from the pre-edge state
  always @(posedge aclk) begin
    if (!areset) begin
      int  lv;
      bit  acc;
      lv  = exp_level();
      acc = (held > 0) && m_axis_tready;
`ifdef DMA_RD_BUF_OVF_EN
      if (if_wr_push && lv == DEPTH) ovf_exp = 1'b1;
`endif
      if (acc) begin
        lane_idx++;
        if (lane_idx == RATIO) begin
          lane_idx = 0;
          held--;
        end
      end
      if (if_wr_push && lv < DEPTH) begin
        held++;
        for (int k = 0; k < RATIO; k++) begin
          lane_t e;
          e.d = if_wr_data[k*OW +: OW];
          e.l = st_last && (k == RATIO - 1);
          sb.push_back(e);
        end
      end
    end
  end

  // Monitor: status flags every cycle, lane contents whenever valid
  always @(negedge aclk) begin
    if (!areset) begin
      int lv;
      lv = exp_level();
      chk("level", level, lv);
      chk("if_wr_ready", if_wr_ready, lv < DEPTH);
      chk("if_wr_req", if_wr_req, (DEPTH - lv) >= BL);
      chk("ovf", ovf, ovf_exp);
      chk("tvalid", m_axis_tvalid, held > 0);
      if (m_axis_tvalid) begin
        if (sb.size() == 0) begin
          chk("unexpected_lane", 1'b1, 1'b0);
        end else begin
          chk("tdata", m_axis_tdata, sb[0].d);
          chk("tlast", m_axis_tlast, sb[0].l);
          if (m_axis_tready) begin
            void'(sb.pop_front());
            hs_cnt++;
          end
        end
      end
    end
  end

  task automatic step(input bit p, input logic [DW-1:0] d, input bit l, input bit r);
    if_wr_push    = p;
    if_wr_data    = d;
    st_last       = l;
    m_axis_tready = r;
    @(posedge aclk);
    #1;
  endtask

  function automatic logic [DW-1:0] rnd_word();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic drain();
    int n = 0;
    while ((held > 0 || sb.size() > 0) && n < 2000) begin
      step(1'b0, '0, 1'b0, 1'b1);
      n++;
    end
    chk("drain_timeout", n < 2000, 1'b1);
    chk("drain_sb_empty", sb.size(), 0);
  endtask

  task automatic do_reset();
    areset        = 1'b1;
    if_wr_push    = 1'b0;
    m_axis_tready = 1'b0;
    sb.delete();
    held     = 0;
    lane_idx = 0;
    ovf_exp  = 1'b0;
    #1;
    chk("rst_tvalid", m_axis_tvalid, 1'b0);
    chk("rst_tlast", m_axis_tlast, 1'b0);
    chk("rst_level", level, 0);
    chk("rst_ovf", ovf, 1'b0);
    chk("rst_wr_ready", if_wr_ready, 1'b1);
    chk("rst_wr_req", if_wr_req, 1'b1);
    repeat (2) @(posedge aclk);
    #1;
    areset = 1'b0;
    @(posedge aclk);
    #1;
  endtask

  initial begin
    logic [DW-1:0] w;
    int n;
    int start;

    do_reset();

    // Single word, lane k carries byte value k
    for (int k = 0; k < RATIO; k++) w[k*OW +: OW] = OW'(k);
    step(1'b1, w, 1'b1, 1'b1);
    chk("latency_tvalid", m_axis_tvalid, 1'b1);
    chk("latency_lane0", m_axis_tdata, 8'h00);
    drain();

    // Fill with output stalled, then one push too many
    n = 0;
    while (exp_level() < DEPTH && n < 100) begin
      step(1'b1, rnd_word(), 1'($urandom_range(0, 1)), 1'b0);
      n++;
    end
    if_wr_push = 1'b0;
    chk("fill_level", level, DEPTH);
    chk("fill_wr_ready", if_wr_ready, 1'b0);
    chk("fill_wr_req", if_wr_req, 1'b0);
    step(1'b1, rnd_word(), 1'b0, 1'b0);
    if_wr_push = 1'b0;
    chk("ovf_level", level, DEPTH);
`ifdef DMA_RD_BUF_OVF_EN
    chk("ovf_set", ovf, 1'b1);
`else
    chk("ovf_clear", ovf, 1'b0);
`endif
    drain();

    // Backpressure: tready toggles every cycle over 4 words
    for (int i = 0; i < 4; i++) step(1'b1, rnd_word(), i == 3, i[0]);
    n = 0;
    while (held > 0 && n < 500) begin
      step(1'b0, '0, 1'b0, n[0]);
      n++;
    end
    drain();

    // Random traffic
    for (int i = 0; i < 800; i++) begin
      step($urandom_range(0, 99) < 40, rnd_word(), 1'($urandom_range(0, 1)),
           $urandom_range(0, 99) < 70);
    end
    drain();

    // Reset after lane 5 of word 2
    start = hs_cnt;
    for (int i = 0; i < 3; i++) step(1'b1, rnd_word(), i == 2, 1'b1);
    n = 0;
    while (hs_cnt < start + 2 * RATIO + 6 && n < 200) begin
      step(1'b0, '0, 1'b0, 1'b1);
      n++;
    end
    chk("midstream_reached", n < 200, 1'b1);
    do_reset();
    for (int k = 0; k < RATIO; k++) w[k*OW +: OW] = OW'(8'hA0 + k);
    step(1'b1, w, 1'b1, 1'b1);
    chk("post_rst_lane0", m_axis_tdata, 8'hA0);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

endmodule
